// File: rtl/memory_frame_pkg.sv
// Shared definitions for the memory frame layout used by the writer and the
// read-back path: state encoding, fixed addresses and capacity helper.
//
// Frame layout in the SRAM:
//   addr 0       : byte count N of the last committed frame
//   addr 1..N    : payload bytes
//   addr N+1     : XOR checksum (only when MEMORY_WRITER_CHECKSUM_EN is set)

package memory_frame_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECV     = 3'd1,
        WR_SUM   = 3'd2,
        WR_COUNT = 3'd3,
        DONE     = 3'd4
    } frame_state_t;

    localparam int COUNT_ADDR      = 0;
    localparam int FIRST_DATA_ADDR = 1;

    // Largest payload length that fits both the address space (address 0 is
    // reserved for the count) and the count word. One slot is given up when
    // a checksum byte follows the payload.
    function automatic int frame_max(input int addr_width,
                                     input int data_width,
                                     input bit sum_en);
        int a_max;
        int d_max;
        int m;
        a_max = (1 << addr_width) - 1;
        d_max = (1 << data_width) - 1;
        m     = (a_max < d_max) ? a_max : d_max;
        return sum_en ? (m - 1) : m;
    endfunction

endpackage

// File: rtl/memory_writer.sv
// memory_writer: stores one byte-stream frame into a single-port SRAM.
// Payload is written to addresses 1..N as it arrives (one byte per cycle
// when the source streams), then the count N is written to address 0, and
// o_done pulses once the frame is complete in memory.
//
// Optional build macro: MEMORY_WRITER_CHECKSUM_EN
//   Adds a running XOR of the payload, written at address N+1 before the
//   count word. Capacity drops by one and o_done arrives one cycle later.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for the first byte of a frame
// RECV     | accepting payload bytes, writing each at r_ptr
// WR_SUM   | writing the payload XOR after the last byte (checksum build)
// WR_COUNT | writing the byte count to address 0
// DONE     | frame committed; o_done registers high on leaving this state

module memory_writer
    import memory_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_overflow,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0
);

`ifdef MEMORY_WRITER_CHECKSUM_EN
    localparam bit           SUM_EN        = 1'b1;
    localparam frame_state_t AFTER_PAYLOAD = WR_SUM;
`else
    localparam bit           SUM_EN        = 1'b0;
    localparam frame_state_t AFTER_PAYLOAD = WR_COUNT;
`endif

    localparam int                    MAX_INT    = frame_max(ADDR_WIDTH, DATA_WIDTH, SUM_EN);
    localparam logic [DATA_WIDTH-1:0] MAX_COUNT  = DATA_WIDTH'(MAX_INT);
    localparam logic [DATA_WIDTH-1:0] ONE_COUNT  = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT = ADDR_WIDTH'(COUNT_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(FIRST_DATA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR   = ADDR_WIDTH'(1);

    frame_state_t          r_state;
    frame_state_t          w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] w_count_nxt;
    logic                  r_overflow;
    logic                  w_overflow_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_csb;
    logic                  w_csb_nxt;
    logic                  r_web;
    logic                  w_web_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_din;
    logic [DATA_WIDTH-1:0] w_din_nxt;

`ifdef MEMORY_WRITER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] w_sum_nxt;
`endif

    logic                  w_full;
    logic                  w_ready;
    logic                  w_fire;
    logic [DATA_WIDTH-1:0] w_count_inc;

    // A finished frame's count does not block the next one: fullness only
    // matters while a frame is being received.
    assign w_full      = (r_state == RECV) && (r_count == MAX_COUNT);
    assign w_ready     = ((r_state == IDLE) || (r_state == RECV)) && !w_full;
    assign w_fire      = i_valid && w_ready;
    assign w_count_inc = r_count + ONE_COUNT;

    assign o_ready    = w_ready;
    assign o_done     = r_done;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign csb0       = r_csb;
    assign web0       = r_web;
    assign addr0      = r_addr;
    assign din0       = r_din;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next datapath values; SRAM strobes default to idle so
    // every write lasts exactly one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_done_nxt     = 1'b0;
        w_csb_nxt      = 1'b1;
        w_web_nxt      = 1'b1;
        w_addr_nxt     = r_addr;
        w_din_nxt      = r_din;
`ifdef MEMORY_WRITER_CHECKSUM_EN
        w_sum_nxt      = r_sum;
`endif

        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_overflow_nxt = 1'b0;
                    w_count_nxt    = ONE_COUNT;
                    w_csb_nxt      = 1'b0;
                    w_web_nxt      = 1'b0;
                    w_addr_nxt     = ADDR_FIRST;
                    w_din_nxt      = i_data;
                    w_ptr_nxt      = ADDR_FIRST + ONE_ADDR;
`ifdef MEMORY_WRITER_CHECKSUM_EN
                    w_sum_nxt      = i_data;
`endif
                    if (i_last || (MAX_COUNT == ONE_COUNT)) begin
                        w_state_nxt = AFTER_PAYLOAD;
                    end else begin
                        w_state_nxt = RECV;
                    end
                end
            end

            RECV: begin
                if (w_fire) begin
                    w_count_nxt = w_count_inc;
                    w_csb_nxt   = 1'b0;
                    w_web_nxt   = 1'b0;
                    w_addr_nxt  = r_ptr;
                    w_din_nxt   = i_data;
                    w_ptr_nxt   = r_ptr + ONE_ADDR;
`ifdef MEMORY_WRITER_CHECKSUM_EN
                    w_sum_nxt   = r_sum ^ i_data;
`endif
                    if (i_last) begin
                        w_state_nxt = AFTER_PAYLOAD;
                    end else if (w_count_inc == MAX_COUNT) begin
                        // Capacity reached without i_last: close the frame
                        // here; the rest of the stream starts a new frame.
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = AFTER_PAYLOAD;
                    end
                end
            end

`ifdef MEMORY_WRITER_CHECKSUM_EN
            WR_SUM: begin
                // r_ptr already points one past the last payload byte.
                w_csb_nxt   = 1'b0;
                w_web_nxt   = 1'b0;
                w_addr_nxt  = r_ptr;
                w_din_nxt   = r_sum;
                w_state_nxt = WR_COUNT;
            end
`endif

            WR_COUNT: begin
                w_csb_nxt   = 1'b0;
                w_web_nxt   = 1'b0;
                w_addr_nxt  = ADDR_COUNT;
                w_din_nxt   = r_count;
                w_state_nxt = DONE;
            end

            DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and SRAM interface registers.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_ptr      <= ADDR_FIRST;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_csb      <= 1'b1;
            r_web      <= 1'b1;
            r_addr     <= '0;
            r_din      <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_done     <= w_done_nxt;
            r_csb      <= w_csb_nxt;
            r_web      <= w_web_nxt;
            r_addr     <= w_addr_nxt;
            r_din      <= w_din_nxt;
        end
    end

`ifdef MEMORY_WRITER_CHECKSUM_EN
    // Running XOR of the current frame's payload.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

endmodule
